// File: rtl/fsx_video_timing.sv
// Configurable raster timing engine: counters, delayed sync/enable, line doubling, IRQs.
// Optional line-compare interrupt is built only when FSX_LINE_IRQ_EN is defined.
module fsx_video_timing #(
    parameter int H_RES       = 320,
    parameter int H_FP        = 24,
    parameter int H_SYNC      = 32,
    parameter int H_BP        = 46,
    parameter int V_RES       = 240,
    parameter int V_FP        = 3,
    parameter int V_SYNC      = 5,
    parameter int V_BP        = 14,
    parameter int H_POL       = 0,
    parameter int V_POL       = 0,
    parameter int PIPE_DELAY  = 2,
    parameter int FRAME_PULSE = 8,
    parameter int H_W         = 10,
    parameter int V_W         = 9
) (
    input  logic           vga_clk,
    input  logic           reset,
    input  logic           v_double,
    input  logic [V_W-1:0] line_cmp,
    output logic [H_W-1:0] o_h,
    output logic [V_W-1:0] o_v,
    output logic           o_de,
    output logic           o_hs,
    output logic           o_vs,
    output logic           crt_sync,
    output logic           frame_irq,
    output logic           line_irq
);

    localparam int H_TOTAL = H_FP + H_SYNC + H_BP + H_RES;
    localparam int HA_STA  = H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_FP + V_SYNC + V_BP + V_RES;
    localparam int VA_STA  = V_FP + V_SYNC + V_BP;

    localparam logic [H_W-1:0] H_LAST     = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_SYNC_STA = H_W'(H_FP);
    localparam logic [H_W-1:0] H_SYNC_END = H_W'(H_FP + H_SYNC);
    localparam logic [H_W-1:0] H_ACT      = H_W'(HA_STA);
    localparam logic [H_W-1:0] H_PULSE    = H_W'(FRAME_PULSE);
    localparam logic [V_W-1:0] V_LAST     = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_SYNC_STA = V_W'(V_FP);
    localparam logic [V_W-1:0] V_SYNC_END = V_W'(V_FP + V_SYNC);
    localparam logic [V_W-1:0] V_ACT      = V_W'(VA_STA);

    localparam logic HS_ON = (H_POL != 0);
    localparam logic VS_ON = (V_POL != 0);

    // Delay-line lane order: {de, vs, hs}, stored at output polarity.
    localparam logic [2:0] SYNC_IDLE = {1'b0, ~VS_ON, ~HS_ON};

    logic [H_W-1:0] h_count_reg;
    logic [V_W-1:0] v_count_reg;
    logic           dbl_reg;

    logic           hs_act;
    logic           vs_act;
    logic           de_now;
    logic [H_W-1:0] h_off;
    logic [V_W-1:0] v_off;
    logic [2:0]     sync_next;

    logic [PIPE_DELAY:0][2:0] sync_pipe_reg;

    // Raster counters: horizontal wraps at H_TOTAL and carries into vertical.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            h_count_reg <= '0;
            v_count_reg <= '0;
        end else if (h_count_reg == H_LAST) begin
            h_count_reg <= '0;
            if (v_count_reg == V_LAST) begin
                v_count_reg <= '0;
            end else begin
                v_count_reg <= v_count_reg + 1'b1;
            end
        end else begin
            h_count_reg <= h_count_reg + 1'b1;
        end
    end

    // Doubling request is latched only at the very first pixel of a frame.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            dbl_reg <= 1'b0;
        end else if ((h_count_reg == '0) && (v_count_reg == '0)) begin
            dbl_reg <= v_double;
        end
    end

    always_comb begin
        hs_act    = (h_count_reg >= H_SYNC_STA) && (h_count_reg < H_SYNC_END);
        vs_act    = (v_count_reg >= V_SYNC_STA) && (v_count_reg < V_SYNC_END);
        de_now    = (h_count_reg >= H_ACT) && (v_count_reg >= V_ACT);
        h_off     = h_count_reg - H_ACT;
        v_off     = v_count_reg - V_ACT;
        sync_next = {de_now,
                     vs_act ? VS_ON : ~VS_ON,
                     hs_act ? HS_ON : ~HS_ON};
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            o_h       <= '0;
            o_v       <= '0;
            frame_irq <= 1'b0;
        end else begin
            o_h       <= de_now ? h_off : '0;
            o_v       <= de_now ? (dbl_reg ? (v_off >> 1) : v_off) : '0;
            frame_irq <= (v_count_reg == '0) && (h_count_reg < H_PULSE);
        end
    end

    // Stage 0 aligns with o_h/o_v; the remaining stages model renderer latency.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            for (int i = 0; i <= PIPE_DELAY; i++) begin
                sync_pipe_reg[i] <= SYNC_IDLE;
            end
        end else begin
            sync_pipe_reg[0] <= sync_next;
            for (int i = PIPE_DELAY; i > 0; i--) begin
                sync_pipe_reg[i] <= sync_pipe_reg[i-1];
            end
        end
    end

    assign o_de     = sync_pipe_reg[PIPE_DELAY][2];
    assign o_vs     = sync_pipe_reg[PIPE_DELAY][1];
    assign o_hs     = sync_pipe_reg[PIPE_DELAY][0];
    assign crt_sync = ~(o_hs ^ o_vs);

`ifdef FSX_LINE_IRQ_EN
    localparam logic [V_W:0]   V_ACT_X = (V_W+1)'(VA_STA);
    localparam logic [V_W-1:0] V_RES_C = V_W'(V_RES);

    logic [V_W:0] cmp_line;
    logic         line_hit;

    // Compare in one extra bit so VA_STA + line_cmp cannot alias a real line.
    always_comb begin
        cmp_line = V_ACT_X + {1'b0, line_cmp};
        line_hit = (line_cmp < V_RES_C) && (h_count_reg == '0)
                   && ({1'b0, v_count_reg} == cmp_line);
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            line_irq <= 1'b0;
        end else begin
            line_irq <= line_hit;
        end
    end
`else
    logic unused_line_cmp;

    assign unused_line_cmp = ^line_cmp;
    assign line_irq        = 1'b0;
`endif

endmodule

// File: tb/tb_fsx_video_timing.sv
// Randomized bench for fsx_video_timing with a position-based raster model.
module tb_fsx_video_timing;

    localparam int HR = 16, HF = 3, HS = 4, HB = 5;
    localparam int VR = 12, VF = 2, VS = 2, VB = 3;
    localparam int PD = 2, FPW = 8;
    localparam int HT = HF + HS + HB + HR;   // 28
    localparam int HA = HF + HS + HB;        // 12
    localparam int VT = VF + VS + VB + VR;   // 19
    localparam int VA = VF + VS + VB;        // 7
    localparam int FT = HT * VT;             // 532
`ifdef FSX_LINE_IRQ_EN
    localparam bit LIEN = 1'b1;
`else
    localparam bit LIEN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       v_double = 1'b0;
    logic [8:0] line_cmp = 9'd5;

    logic [9:0] o_h, o_h0;
    logic [8:0] o_v, o_v0;
    logic o_de, o_hs, o_vs, crt_sync, frame_irq, line_irq;
    logic o_de0, o_hs0, o_vs0, crt_sync0, frame_irq0, line_irq0;

    always #5 clk = ~clk;

    fsx_video_timing #(
        .H_RES(HR), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_RES(VR), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(0), .V_POL(0), .PIPE_DELAY(PD), .FRAME_PULSE(FPW),
        .H_W(10), .V_W(9)
    ) dut (
        .vga_clk(clk), .reset(reset), .v_double(v_double), .line_cmp(line_cmp),
        .o_h(o_h), .o_v(o_v), .o_de(o_de), .o_hs(o_hs), .o_vs(o_vs),
        .crt_sync(crt_sync), .frame_irq(frame_irq), .line_irq(line_irq)
    );

    fsx_video_timing #(
        .H_RES(HR), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_RES(VR), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_POL(0), .V_POL(0), .PIPE_DELAY(0), .FRAME_PULSE(FPW),
        .H_W(10), .V_W(9)
    ) dut0 (
        .vga_clk(clk), .reset(reset), .v_double(v_double), .line_cmp(line_cmp),
        .o_h(o_h0), .o_v(o_v0), .o_de(o_de0), .o_hs(o_hs0), .o_vs(o_vs0),
        .crt_sync(crt_sync0), .frame_irq(frame_irq0), .line_irq(line_irq0)
    );

    int vectors = 0;
    int miscompares = 0;

    function automatic void check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Raster position q clocks after reset release; negative means pipe still idle.
    function automatic bit hs_at(input int q);
        int h;
        if (q < 0) return 1'b0;
        h = (q % FT) % HT;
        return (h >= HF) && (h < HF + HS);
    endfunction

    function automatic bit vs_at(input int q);
        int v;
        if (q < 0) return 1'b0;
        v = (q % FT) / HT;
        return (v >= VF) && (v < VF + VS);
    endfunction

    function automatic bit de_at(input int q);
        int h, v;
        if (q < 0) return 1'b0;
        h = (q % FT) % HT;
        v = (q % FT) / HT;
        return (h >= HA) && (v >= VA);
    endfunction

    // Inputs as the DUT saw them at the most recent rising edge.
    logic       s_reset;
    logic       s_vdbl;
    logic [8:0] s_cmp;
    always @(posedge clk) begin
        s_reset <= reset;
        s_vdbl  <= v_double;
        s_cmp   <= line_cmp;
    end

    int cnt = 0;
    bit m_dbl = 1'b0;

    always @(negedge clk) begin : compare
        int p, h, v, e_h, e_v;
        bit e_fr, e_li, e_de, e_hs, e_vs, e_de0, e_hs0, act;
        if (!$isunknown(s_reset)) begin
            if (s_reset) begin
                e_h = 0; e_v = 0; e_fr = 0; e_li = 0;
                e_de = 0; e_hs = 1; e_vs = 1; e_de0 = 0; e_hs0 = 1;
                cnt = 0;
                m_dbl = 1'b0;
            end else begin
                p = cnt % FT;
                h = p % HT;
                v = p / HT;
                act = (h >= HA) && (v >= VA);
                e_h = act ? h - HA : 0;
                e_v = act ? (m_dbl ? (v - VA) / 2 : v - VA) : 0;
                e_fr = (v == 0) && (h < FPW);
                e_li = LIEN && (h == 0) && (s_cmp < VR) && (v == VA + int'(s_cmp));
                e_de = de_at(cnt - PD);
                e_hs = !hs_at(cnt - PD);
                e_vs = !vs_at(cnt - PD);
                e_de0 = de_at(cnt);
                e_hs0 = !hs_at(cnt);
                if (p == 0) m_dbl = s_vdbl;
                cnt++;
            end
            check("o_h", o_h, e_h);
            check("o_v", o_v, e_v);
            check("frame_irq", frame_irq, e_fr);
            check("line_irq", line_irq, e_li);
            check("o_de", o_de, e_de);
            check("o_hs", o_hs, e_hs);
            check("o_vs", o_vs, e_vs);
            check("crt_sync", crt_sync, !(e_hs ^ e_vs));
            check("o_de_pd0", o_de0, e_de0);
            check("o_hs_pd0", o_hs0, e_hs0);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic tally(input int n, output int c_de, output int c_hs, output int c_vs,
                         output int c_fr, output int c_li, output int c_vsum, output int c_de0);
        c_de = 0; c_hs = 0; c_vs = 0; c_fr = 0; c_li = 0; c_vsum = 0; c_de0 = 0;
        repeat (n) begin
            @(negedge clk);
            c_de += int'(o_de);
            c_hs += int'(o_hs == 1'b0);
            c_vs += int'(o_vs == 1'b0);
            c_fr += int'(frame_irq);
            c_li += int'(line_irq);
            c_vsum += int'(o_v);
            c_de0 += int'(o_de0);
        end
    endtask

    initial begin : stim
        int c_de, c_hs, c_vs, c_fr, c_li, c_vsum, c_de0;
        reset = 1'b1;
        v_double = 1'b0;
        line_cmp = 9'd5;
        step(3);
        reset = 1'b0;

        // Outputs right after the last reset edge, then first live edge.
        @(negedge clk);
        check("rst_o_h", o_h, 0);
        check("rst_o_de", o_de, 0);
        check("rst_o_hs", o_hs, 1);
        check("rst_crt_sync", crt_sync, 1);
        check("rst_frame_irq", frame_irq, 0);
        @(negedge clk);
        check("first_frame_irq", frame_irq, 1);

        // Whole-frame totals: 16x12 active, 4-clk hsync per line, 2-line vsync.
        step(FT);
        tally(FT, c_de, c_hs, c_vs, c_fr, c_li, c_vsum, c_de0);
        check("frame_de_count", c_de, 192);
        check("frame_de0_count", c_de0, 192);
        check("frame_hs_low", c_hs, 76);
        check("frame_vs_low", c_vs, 56);
        check("frame_irq_width", c_fr, 8);
        check("line_irq_count", c_li, LIEN ? 1 : 0);
        check("o_v_sum_single", c_vsum, 1056);

        line_cmp = 9'd12;
        step(2);
        tally(FT, c_de, c_hs, c_vs, c_fr, c_li, c_vsum, c_de0);
        check("line_irq_out_of_range", c_li, 0);

        // Doubling requested mid-frame; settles one frame later.
        line_cmp = 9'd5;
        step(FT / 3);
        v_double = 1'b1;
        step(FT + 2);
        tally(FT, c_de, c_hs, c_vs, c_fr, c_li, c_vsum, c_de0);
        check("o_v_sum_double", c_vsum, 480);
        check("frame_de_count_dbl", c_de, 192);

        // Random toggles of doubling, compare line and short resets.
        step(1);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) v_double = ~v_double;
            if ($urandom_range(0, 99) == 0) line_cmp = 9'($urandom_range(0, 15));
            reset = ($urandom_range(0, 699) == 0);
            step(1);
        end

        // Mid-frame reset, then frame_irq must start on the first live edge.
        reset = 1'b0;
        step(300);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_o_de", o_de, 0);
        check("midrst_o_v", o_v, 0);
        tally(10, c_de, c_hs, c_vs, c_fr, c_li, c_vsum, c_de0);
        check("midrst_frame_irq_width", c_fr, 8);

        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
